mult_seq_responder: RTL and testbench
=====================================

// Module: mult_seq_responder
// PURPOSE
//   Responder end of the start/done coprocessor handshake: accepts a start
//   request with two unsigned operands and computes their product by
//   shift-and-add, one bit per cycle. Signals completion with a one-cycle
//   done pulse and holds the product on result. Sits beneath the control FSM
//   that issues start and waits on done.
// PARAMETERS
//   WIDTH    8    operand width in bits (>=2); result is 2*WIDTH bits
//   (local) CNT_W = $clog2(WIDTH+1)   iteration counter width
// PORTS
//   clk      in   1        system clock, all state on rising edge
//   reset_n  in   1        asynchronous, active-low reset
//   start    in   1        request; sampled only in IDLE
//   op_a     in   WIDTH    multiplicand, captured on accepted start
//   op_b     in   WIDTH    multiplier, captured on accepted start
//   busy     out  1        1 while in RUN or FINISH
//   done     out  1        1 for exactly one cycle (state FINISH)
//   result   out  2*WIDTH  unsigned product; holds until next completion
// BEHAVIOUR
//   - Reset (reset_n=0, async): state=IDLE, busy=0, done=0, result=0,
//     internal acc/mcand/mplier/cnt=0. Takes effect immediately, any state.
//   - States: IDLE=2'b00, RUN=2'b01, FINISH=2'b10; 2'b11 -> IDLE.
//   - IDLE: start=1 at edge E0 -> RUN; mcand<={WIDTH'b0,op_a},
//     mplier<=op_b, acc<=0, cnt<=0. start=0 -> stay IDLE.
//   - RUN, each edge: if mplier[0] acc<=acc+mcand; mcand<=mcand<<1;
//     mplier<=mplier>>1; cnt<=cnt+1. acc is 2*WIDTH bits, never overflows
//     (max (2^W-1)^2 < 2^2W); no truncation allowed.
//   - RUN at cnt==WIDTH-1: final iteration; result<=acc_next (same edge);
//     state -> FINISH. Exactly WIDTH RUN cycles, independent of operand
//     values (no early exit on zero).
//   - FINISH: done=1, busy=1; next edge -> IDLE unconditionally.
//   - Latency: done high in the cycle after edge E_WIDTH (WIDTH cycles after
//     the accepting edge E0); back in IDLE after E_(WIDTH+1); earliest next
//     accept at E_(WIDTH+2). start held high -> one op per WIDTH+2 cycles.
//   - Outputs are Moore: busy=(state!=IDLE), done=(state==FINISH).
//   - start in RUN/FINISH ignored; no queuing; operands not recaptured.
//   - op_a/op_b changes after E0 have no effect on the running op.
//   - result changes only at the edge entering FINISH or on reset; stays
//     stable through IDLE and the next RUN.
//   - Reset mid-RUN: operation abandoned, no done pulse, result=0.
// TESTING
//   1. reset_n=0 any state -> busy=0, done=0, result=0 immediately.
//   2. WIDTH=8, op_a=13, op_b=11, start 1 cycle -> busy 9 cycles,
//      done 1 cycle 8 cycles after E0, result=16'h008F.
//   3. op_a=255, op_b=255 -> result=16'hFE01, same latency.
//   4. op_a=0, op_b=200 -> result=0, still 8 RUN cycles then done.
//   5. start held high; op_a/op_b changed mid-RUN -> first result from
//      captured values; done pulses every 10 cycles; start ignored in RUN.
//   6. reset_n low 1 cycle at RUN cnt=4 -> no done, result=0; subsequent
//      start 7*9 -> result=16'h003F with normal latency.

Source files
------------

// File: rtl/mult_seq_responder.sv
// Shift-and-add multiplier answering a start/done handshake.
// It processes one multiplier bit per cycle and always runs exactly WIDTH
// iterations. It gives a single-cycle done pulse and holds result until the
// next completion.
module mult_seq_responder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned RES_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FINISH = 2'b10
   } state_e;

   state_e             state_q, state_d;
   logic [RES_W-1:0]   acc_q, acc_d;
   logic [RES_W-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [RES_W-1:0]   acc_next;

   // Next-state, datapath step and registered-output decode
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               mcand_d  = RES_W'(op_a);
               mplier_d = op_b;
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         RUN: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Last iteration: publish the sum including this cycle's add
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = acc_next;
               state_d  = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they flop alongside it
      busy_d = (state_d != IDLE);
      done_d = (state_d == FINISH);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mult_seq_responder.sv
// Bench for mult_seq_responder.
// A timer-based reference model predicts busy, done and result from the
// start/operand history. Scenario tasks compare against the model and
// against fixed expected values.
module tb_mult_seq_responder;

   localparam int unsigned W     = 8;
   localparam int unsigned RES_W = 2 * W;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic             busy;
   logic             done;
   logic [RES_W-1:0] result;

   int checks;
   int failures;

   mult_seq_responder #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an accepted op occupies W+2 cycles counted down by m_rem.
   // The product appears when m_rem reaches 1, which is the done cycle.
   int               m_rem;
   logic [RES_W-1:0] m_pending;
   logic [RES_W-1:0] m_result;
   logic             m_busy;
   logic             m_done;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_rem     <= 0;
         m_pending <= '0;
         m_result  <= '0;
      end else if (m_rem == 0) begin
         if (start) begin
            m_rem     <= W + 1;
            m_pending <= RES_W'(op_a) * RES_W'(op_b);
         end
      end else begin
         if (m_rem == 2) m_result <= m_pending;
         m_rem <= m_rem - 1;
      end
   end

   assign m_busy = (m_rem != 0);
   assign m_done = (m_rem == 1);

   // Reset asserted: every output must be zero immediately
   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      op_a    = '0;
      op_b    = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Single-shot ops with known products, exact latency and operand scrambling
   task automatic test_directed();
      logic [W-1:0]     da [3];
      logic [W-1:0]     db [3];
      logic [RES_W-1:0] dr [3];
      logic [RES_W-1:0] prev;
      da[0] = 8'd13;  db[0] = 8'd11;  dr[0] = 16'h008F;
      da[1] = 8'd255; db[1] = 8'd255; dr[1] = 16'hFE01;
      da[2] = 8'd0;   db[2] = 8'd200; dr[2] = 16'h0000;
      prev = m_result;
      for (int k = 0; k < 3; k++) begin
         start = 1'b1;
         op_a  = da[k];
         op_b  = db[k];
         for (int i = 0; i <= int'(W) + 1; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== (i <= int'(W))) begin
               failures++; $display("FAIL dir%0d_busy cyc=%0d got=%b exp=%b", k, i, busy, (i <= int'(W)));
            end
            checks++;
            if (done !== (i == int'(W))) begin
               failures++; $display("FAIL dir%0d_done cyc=%0d got=%b exp=%b", k, i, done, (i == int'(W)));
            end
            checks++;
            if (result !== ((i >= int'(W)) ? dr[k] : prev)) begin
               failures++; $display("FAIL dir%0d_result cyc=%0d got=%h exp=%h", k, i, result,
                                    (i >= int'(W)) ? dr[k] : prev);
            end
            start = 1'b0;
            op_a  = W'($urandom);
            op_b  = W'($urandom);
         end
         prev = dr[k];
      end
   endtask

   // start held high with operands changing every cycle
   task automatic test_back_to_back();
      int               done_cyc [$];
      logic [RES_W-1:0] first_exp;
      start = 1'b1;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      first_exp = RES_W'(op_a) * RES_W'(op_b);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== m_busy) begin failures++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", i, busy, m_busy); end
         checks++;
         if (done !== m_done) begin failures++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", i, done, m_done); end
         checks++;
         if (result !== m_result) begin failures++; $display("FAIL b2b_result cyc=%0d got=%h exp=%h", i, result, m_result); end
         if (done === 1'b1) begin
            if (done_cyc.size() == 0) begin
               checks++;
               if (result !== first_exp) begin
                  failures++; $display("FAIL b2b_first_result got=%h exp=%h", result, first_exp);
               end
            end
            done_cyc.push_back(i);
         end
         op_a = W'($urandom);
         op_b = W'($urandom);
      end
      start = 1'b0;
      checks++;
      if (done_cyc.size() != 3) begin
         failures++; $display("FAIL b2b_pulse_count got=%0d exp=3", done_cyc.size());
      end
      for (int j = 1; j < done_cyc.size(); j++) begin
         checks++;
         if (done_cyc[j] - done_cyc[j-1] != int'(W) + 2) begin
            failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", done_cyc[j] - done_cyc[j-1], W + 2);
         end
      end
      repeat (W + 2) @(negedge clk);
   endtask

   // Random start/operand traffic compared cycle by cycle with the model
   task automatic test_random();
      int n_done;
      n_done = 0;
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 3) == 0);
         op_a  = W'($urandom);
         op_b  = W'($urandom);
         @(negedge clk);
         checks++;
         if (busy !== m_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, m_busy); end
         checks++;
         if (done !== m_done) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, done, m_done); end
         checks++;
         if (result !== m_result) begin failures++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", i, result, m_result); end
         if (m_done) n_done++;
      end
      start = 1'b0;
      repeat (W + 2) @(negedge clk);
      checks++;
      if (n_done < 5) begin failures++; $display("FAIL rnd_activity got=%0d exp>=5", n_done); end
   endtask

   // Reset pulse in the middle of RUN, then a clean op afterwards
   task automatic test_reset_mid_run();
      start = 1'b1;
      op_a  = 8'd200;
      op_b  = 8'd3;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
      checks++;
      if (result !== '0) begin failures++; $display("FAIL midrst_result got=%h exp=0", result); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            failures++; $display("FAIL midrst_quiet cyc=%0d got=%b/%b/%h exp=0/0/0", i, busy, done, result);
         end
      end
      start = 1'b1;
      op_a  = 8'd7;
      op_b  = 8'd9;
      for (int i = 0; i <= int'(W) + 1; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (done !== (i == int'(W))) begin
            failures++; $display("FAIL post_done cyc=%0d got=%b exp=%b", i, done, (i == int'(W)));
         end
         checks++;
         if (busy !== (i <= int'(W))) begin
            failures++; $display("FAIL post_busy cyc=%0d got=%b exp=%b", i, busy, (i <= int'(W)));
         end
         checks++;
         if (result !== ((i >= int'(W)) ? 16'h003F : 16'h0000)) begin
            failures++; $display("FAIL post_result cyc=%0d got=%h exp=%h", i, result,
                                 (i >= int'(W)) ? 16'h003F : 16'h0000);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog: the scenarios are bounded loops, so this only fires on a stall
   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
